mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Fixed-latency single-port memory responder for a cache model.
//               It accepts one request in IDLE and counts LATENCY edges in
//               BUSY. It then completes in RESP with a one-cycle ack pulse and
//               returns to IDLE.
//               Optional feature macro: MEM_OOR_ERR_EN. When it is defined,
//               addresses with upper bits set report err and have no effect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        ready,
  output logic        ack
`ifdef MEM_OOR_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int          c_DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0]  c_LOAD  = 4'(LATENCY - 1);

  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_BUSY  = 2'd1;
  localparam logic [1:0]  c_RESP  = 2'd2;

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic                 r_wr;
  logic [ADDR_BITS-1:0] r_idx;
  logic [31:0]          r_data;
  logic [31:0]          r_q;
  logic                 r_ack;
  logic [31:0]          r_mem [c_DEPTH];

  logic                 w_capture;
  logic                 w_done;
  logic                 w_oor_now;
  logic                 w_oor;

  // Requests are taken only in IDLE. Completion is the last BUSY edge.
  assign w_capture = (r_state == c_IDLE) && enable;
  assign w_done    = (r_state == c_BUSY) && (r_cnt == 4'd0);

`ifdef MEM_OOR_ERR_EN
  logic r_oor;
  logic r_err;

  assign w_oor_now = |addr[31:ADDR_BITS];
  assign w_oor     = r_oor;
  assign err       = r_err;

  // The out-of-range flag is captured with the request. err pulses with ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_oor <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_oor <= w_oor_now;
      end
      r_err <= w_done && r_oor;
    end
  end
`else
  // Upper address bits alias onto the low index, so they are intentionally dropped.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^addr[31:ADDR_BITS];
  assign w_oor_now        = 1'b0;
  assign w_oor            = w_oor_now;
`endif

  // Control FSM and latency down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (enable) begin
            r_state <= c_BUSY;
            r_cnt   <= c_LOAD;
          end
        end
        c_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Request capture; later input changes must not reach the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr   <= 1'b0;
      r_idx  <= '0;
      r_data <= 32'd0;
    end else if (w_capture) begin
      r_wr   <= wr;
      r_idx  <= addr[ADDR_BITS-1:0];
      r_data <= data;
    end
  end

  // Memory array. Reset leaves it alone; writes commit only at completion.
  always_ff @(posedge clk) begin
    if (!reset && w_done && r_wr && !w_oor) begin
      r_mem[r_idx] <= r_data;
    end
  end

  // Read data and ack are registered. q changes only when a read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= 32'd0;
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_done;
      if (w_done && !r_wr) begin
        r_q <= w_oor ? 32'd0 : r_mem[r_idx];
      end
    end
  end

  assign q     = r_q;
  assign ack   = r_ack;
  assign ready = (r_state == c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder. Instance dut
//               uses ADDR_BITS=6 and LATENCY=3. Instance dut1 uses
//               ADDR_BITS=6 and LATENCY=1. Build with MEM_OOR_ERR_EN defined
//               to enable the err checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, wr;
  logic [31:0] addr, data;
  logic [31:0] q;
  logic        ready, ack;
  logic        b_enable, b_wr;
  logic [31:0] b_addr, b_data;
  logic [31:0] b_q;
  logic        b_ready, b_ack;
`ifdef MEM_OOR_ERR_EN
  logic        err, b_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(6), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr(wr), .addr(addr),
    .data(data), .q(q), .ready(ready), .ack(ack)
`ifdef MEM_OOR_ERR_EN
    , .err(err)
`endif
  );

  mem_responder #(.ADDR_BITS(6), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .enable(b_enable), .wr(b_wr), .addr(b_addr),
    .data(b_data), .q(b_q), .ready(b_ready), .ack(b_ack)
`ifdef MEM_OOR_ERR_EN
    , .err(b_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on dut. After capture, the request inputs are scrambled
  // so that any late sampling shows up. lat is the number of edges from the
  // capture edge to the edge that raises ack, or 99 if ack never arrives.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    int guard = 0;
    while (!ready && guard < 20) begin
      tick();
      guard++;
    end
    enable = 1'b1; wr = w; addr = a; data = d;
    tick();
    enable = 1'b0; wr = ~w; addr = a + 32'd1; data = ~d;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack) begin
        lat = i;
        break;
      end
    end
    tick();
  endtask

  // Issue one request on dut1 and check its cycle-by-cycle handshake.
  task automatic lat1_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    b_enable = 1'b1; b_wr = w; b_addr = a; b_data = d;
    tick();
    b_enable = 1'b0; b_addr = a + 32'd3; b_data = ~d;
    check("l1_busy_ack",   {31'd0, b_ack},   32'd0);
    check("l1_busy_ready", {31'd0, b_ready}, 32'd0);
    tick();
    check("l1_resp_ack",   {31'd0, b_ack},   32'd1);
    tick();
    check("l1_after_ack",  {31'd0, b_ack},   32'd0);
    check("l1_ready_back", {31'd0, b_ready}, 32'd1);
  endtask

  initial begin
    int         lat;
    int         acks;
    int         caps;
    logic [11:0] ack_mask;
    logic [11:0] rdy_mask;
    logic       rdy_before;

    reset = 1'b1; enable = 1'b0; wr = 1'b0; addr = 32'd0; data = 32'd0;
    b_enable = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_ack",   {31'd0, ack},   32'd0);
    check("rst_q",     q,              32'd0);

    // Basic write followed by a read of the same word.
    do_req(1'b1, 32'd5, 32'hDEADBEEF, lat);
    check("wr5_lat", lat, 32'd3);
    check("wr5_q_unchanged", q, 32'd0);
    do_req(1'b0, 32'd5, 32'h0, lat);
    check("rd5_lat", lat, 32'd3);
    check("rd5_q", q, 32'hDEADBEEF);
    check("rd5_ack_pulse", {31'd0, ack}, 32'd0);
    check("rd5_ready_back", {31'd0, ready}, 32'd1);

    // Enable held high for 12 edges. Requests are captured at edges 0, 5 and
    // 10, and ack follows edges 3 and 8.
    enable = 1'b1; wr = 1'b0; addr = 32'd5;
    ack_mask = '0; rdy_mask = '0;
    for (int i = 0; i < 12; i++) begin
      rdy_before = ready;
      tick();
      rdy_mask[i] = rdy_before;
      ack_mask[i] = ack;
    end
    enable = 1'b0;
    acks = 0; caps = 0;
    for (int i = 0; i < 12; i++) begin
      acks += int'(ack_mask[i]);
      caps += int'(rdy_mask[i]);
    end
    check("b2b_rdy_mask", {20'd0, rdy_mask}, 32'h421);
    check("b2b_ack_mask", {20'd0, ack_mask}, 32'h108);
    check("b2b_caps", caps, 32'd3);
    check("b2b_no_double_ack", {31'd0, |(ack_mask & (ack_mask >> 1))}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("b2b_q", q, 32'hDEADBEEF);

    // Reset mid-write aborts the write and its ack.
    do_req(1'b1, 32'd7, 32'hA5A50007, lat);
    check("wr7_lat", lat, 32'd3);
    enable = 1'b1; wr = 1'b1; addr = 32'd7; data = 32'h1234;
    tick();
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_q", q, 32'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(ack);
    end
    check("midrst_no_ack", acks, 32'd0);
    do_req(1'b0, 32'd7, 32'h0, lat);
    check("rd7_q_prior", q, 32'hA5A50007);

    // Reset wins over enable on the same edge.
    enable = 1'b1; reset = 1'b1; wr = 1'b1; addr = 32'd7; data = 32'h55;
    tick();
    enable = 1'b0; reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(ack);
    end
    check("rstprio_no_ack", acks, 32'd0);
    do_req(1'b0, 32'd7, 32'h0, lat);
    check("rstprio_mem7", q, 32'hA5A50007);

    // Input stability: do_req moves addr to 10 and inverts data during BUSY.
    do_req(1'b1, 32'd10, 32'h10101010, lat);
    do_req(1'b1, 32'd9, 32'h99999999, lat);
    do_req(1'b0, 32'd9, 32'h0, lat);
    check("stab_mem9", q, 32'h99999999);
    do_req(1'b0, 32'd10, 32'h0, lat);
    check("stab_mem10", q, 32'h10101010);

    // Out-of-range access to 0x40.
    do_req(1'b1, 32'd0, 32'hC0C0C0C0, lat);
`ifdef MEM_OOR_ERR_EN
    enable = 1'b1; wr = 1'b0; addr = 32'h40;
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    check("oor_ack", {31'd0, ack}, 32'd1);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_q", q, 32'd0);
    tick();
    check("oor_err_pulse", {31'd0, err}, 32'd0);
    do_req(1'b1, 32'h41, 32'hBADBAD, lat);
    do_req(1'b0, 32'd1, 32'h0, lat);
    check("oor_no_write_q", q === 32'h00BADBAD ? 32'd1 : 32'd0, 32'd0);
`else
    do_req(1'b0, 32'h40, 32'h0, lat);
    check("oor_alias_lat", lat, 32'd3);
    check("oor_alias_q", q, 32'hC0C0C0C0);
`endif

    // LATENCY=1 instance.
    lat1_req(1'b1, 32'd0, 32'h0BADF00D);
    lat1_req(1'b0, 32'd0, 32'h0);
    check("l1_rd_q", b_q, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
